// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store controller.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LD     = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WR     = 3'd3,
    ST_ERR    = 3'd4
  } lsu_state_t;

  // Stores only know SB/SH/SW; loads reject the three unused width codes.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    return we ? (f3 > F3_SW) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Request/response bus from the core and word-wide bus to data memory.
interface lsu_req_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [DATA_W-1:0] resp_rdata;

  modport master (output req_valid, req_we, req_funct3, req_addr, req_wdata,
                  input  req_ready, resp_valid, resp_err, resp_rdata);
  modport slave  (input  req_valid, req_we, req_funct3, req_addr, req_wdata,
                  output req_ready, resp_valid, resp_err, resp_rdata);
endinterface

interface lsu_mem_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_we, mem_addr, mem_wdata, input  mem_rdata);
  modport slave  (input  mem_we, mem_addr, mem_wdata, output mem_rdata);
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: load extract/extend and sub-word store merge.
module lsu_lane_align
  import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] st_word_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v    = rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_v    = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        ld_data_o = '0;
        case (funct3_i)
            F3_LB:   ld_data_o = {{24{byte_v[7]}}, byte_v};
            F3_LH:   ld_data_o = {{16{half_v[15]}}, half_v};
            F3_LW:   ld_data_o = rdata_i;
            F3_LBU:  ld_data_o = {24'd0, byte_v};
            F3_LHU:  ld_data_o = {16'd0, half_v};
            default: ld_data_o = '0;
        endcase

        // Halfword lane is chosen by addr[1] alone, so a misaligned SH lands on its natural half.
        st_word_o = rdata_i;
        case (funct3_i[1:0])
            2'd0: st_word_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
            2'd1: begin
                if (addr_lo_i[1]) st_word_o[31:16] = wdata_i[15:0];
                else              st_word_o[15:0]  = wdata_i[15:0];
            end
            default: st_word_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store controller; sub-word stores done as read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned LH/LHU/SH/LW/SW instead of truncating.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    lsu_req_if.slave  req,
    lsu_mem_if.master mem
);

    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_LD     = ST_LD;
    localparam logic [2:0] S_RMW_RD = ST_RMW_RD;
    localparam logic [2:0] S_WR     = ST_WR;
    localparam logic [2:0] S_ERR    = ST_ERR;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        f3_q;
    logic [DATA_W-1:0] wdata_q, merge_q, rdata_q;
    logic              resp_valid_q, resp_err_q;
    logic              misalign, fault;
    logic [DATA_W-1:0] ld_data, st_word;

    lsu_lane_align u_align (
        .funct3_i (f3_q),
        .addr_lo_i(addr_q[1:0]),
        .rdata_i  (mem.mem_rdata),
        .wdata_i  (wdata_q),
        .ld_data_o(ld_data),
        .st_word_o(st_word)
    );

    always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
        misalign = (req.req_funct3[1:0] == 2'd1 && req.req_addr[0]) ||
                   (req.req_funct3[1:0] == 2'd2 && req.req_addr[1:0] != 2'b00);
`else
        misalign = 1'b0;
`endif
        fault = f3_illegal(req.req_we, req.req_funct3) || misalign;
    end

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE: begin
                if (!req.req_valid)            state_d = S_IDLE;
                else if (fault)                state_d = S_ERR;
                else if (!req.req_we)          state_d = S_LD;
                else if (req.req_funct3 == F3_SW) state_d = S_WR;
                else                           state_d = S_RMW_RD;
            end
            S_RMW_RD: state_d = S_WR;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            f3_q         <= '0;
            wdata_q      <= '0;
            merge_q      <= '0;
            rdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            case (state_q)
                S_IDLE: if (req.req_valid) begin
                    addr_q  <= req.req_addr;
                    f3_q    <= req.req_funct3;
                    wdata_q <= req.req_wdata;
                end
                S_LD: begin
                    resp_valid_q <= 1'b1;
                    rdata_q      <= ld_data;
                end
                S_RMW_RD: merge_q <= st_word;
                S_WR: begin
                    resp_valid_q <= 1'b1;
                    rdata_q      <= '0;
                end
                S_ERR: begin
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b1;
                    rdata_q      <= '0;
                end
                default: ;
            endcase
        end
    end

    // Memory controls decode straight from state so an async reset drops mem_we at once.
    always_comb begin
        mem.mem_we    = (state_q == S_WR);
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        if (state_q == S_LD || state_q == S_RMW_RD || state_q == S_WR)
            mem.mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
        if (state_q == S_WR)
            mem.mem_wdata = (f3_q == F3_SW) ? wdata_q : merge_q;
    end

    assign req.req_ready  = (state_q == S_IDLE);
    assign req.resp_valid = resp_valid_q;
    assign req.resp_err   = resp_err_q;
    assign req.resp_rdata = rdata_q;

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store controller that sits between the core's execute stage and the word-addressed data memory, acting as the initiator on the memory's read/write interface. It accepts RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) and issues word-aligned memory accesses. Sub-word loads are extracted and extended. Sub-word stores are performed as a read-modify-write, because the memory only writes whole words.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, data word width; fixed at 32 for RV32

Ports:
- clk  in  1  clock; memory writes on the same rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid & req_ready
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width/sign code
- req_addr  in  ADDR_W  byte address (ALU result)
- req_wdata  in  DATA_W  store data; low byte/half used for SB/SH
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  qualifies resp_valid; misaligned access or illegal funct3
- resp_rdata  out  DATA_W  extended load data; 0 for stores and errors
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  {addr[31:2],2'b00}
- mem_wdata  out  DATA_W  full word to write
- mem_rdata  in  DATA_W  asynchronous memory read data

## Operation
- States: IDLE, LD, RMW_RD, WR, ERR.
- **IDLE**
  - On accept, register addr/funct3/wdata/we.
  - Next state: ERR if the request is faulty; LD for a load; WR for SW; RMW_RD for SB/SH.
- **LD**
  - Drive mem_addr. Select the byte or half at addr[1:0] from mem_rdata.
  - Sign-extend for LB/LH; zero-extend for LBU/LHU; pass LW through.
  - Register the result into resp_rdata. Next state: IDLE with resp_valid=1.
- **RMW_RD**
  - Drive mem_addr with mem_we=0. Capture mem_rdata into the merge register.
  - Replace lane addr[1:0] (SB) or half addr[1] (SH) with req_wdata[7:0]/[15:0]. Next state: WR.
- **WR**
  - Drive mem_we=1 with the merged word (or req_wdata for SW). Next state: IDLE with resp_valid=1.
- **ERR**
  - No memory access; mem_we stays 0. Next state: IDLE with resp_valid=1, resp_err=1.
- Illegal funct3:
  - Loads: 3, 6, 7.
  - Stores: any value other than 0, 1, 2.
- mem_we and mem_addr are combinational from state and registers. Outside LD/RMW_RD/WR: mem_we=0 and mem_addr=0.
- resp_rdata holds its last load value until the next response; it is 0 on a store or error response.

## Timing
- Reset (asynchronous, immediate): state=IDLE, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0, req_ready=1.
- Reset asserted in WR deasserts mem_we before the edge. No partial write is required to land.
- Accept at edge E0. resp_valid is high in the cycle after:
  - E1 for ERR, LD and SW.
  - E2 for SB/SH.
- The memory write commits at E1 for SW and at E2 for SB/SH.
- req_ready=1 in the cycle resp_valid is high, so back-to-back requests are allowed. A store followed immediately by a load to the same word returns the new data.
- req_valid held while not ready is ignored. The requester must keep the request stable until accepted.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - LH/LHU/SH with addr[0]=1 → ERR.
  - LW/SW with addr[1:0]≠0 → ERR.
- LSU_MISALIGN_TRAP_EN undefined:
  - No alignment check. The address is forced down to the natural boundary: halfword uses addr[1], word ignores addr[1:0].
  - The access proceeds normally; resp_err is raised only for illegal funct3.

## Structure
- Shared package lsu_pkg:
  - funct3 constants F3_LB=0, F3_LH=1, F3_LW=2, F3_LBU=4, F3_LHU=5, F3_SB=0, F3_SH=1, F3_SW=2.
  - State enum lsu_state_t.
- Sub-module lsu_lane_align:
  - Purely combinational.
  - Load path: extract and extend.
  - Store path: merge a byte/half into a word by funct3 and addr[1:0].
  - Instantiated once; the FSM stays in lsu_mem_ctrl.

## Test plan
- Memory word 0x40 preloaded with 0x8899AABB:
  - LB at 0x43 → resp_rdata 0xFFFFFF88.
  - LBU at 0x43 → 0x00000088.
  - LH at 0x42 → 0xFFFF8899.
  - Each with resp_valid one cycle after accept.
- SW 0x12345678 at 0x40, then SB 0xEE at 0x41 → word 0x40 = 0x1234EE78. mem_we is high exactly one cycle per store. SB resp_valid appears 2 cycles after accept.
- SH 0xCAFE at 0x42 over 0x1234EE78 → 0xCAFEEE78. A back-to-back LW at 0x40 returns 0xCAFEEE78.
- With LSU_MISALIGN_TRAP_EN, LW at 0x41 → resp_err=1, resp_rdata=0, mem_we never asserted. Without the macro, the same access returns word 0x40.
- Load with funct3=3 → resp_err=1. Store with funct3=4 → resp_err=1 and memory unchanged.
- rst_n pulsed low during the RMW_RD of an SB → all outputs at reset values, target word unchanged, req_ready=1 after release.
